// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter: two requester ports and one result port.
interface alu_arbiter_if #(parameter int W = 16);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_x;
   logic [W-1:0] req0_y;
   logic [5:0]   req0_ctl;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_x;
   logic [W-1:0] req1_y;
   logic [5:0]   req1_ctl;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_out;
   logic         rsp_zr;
   logic         rsp_ng;

   modport master (
      output req0_valid, req0_x, req0_y, req0_ctl, input req0_ready,
      output req1_valid, req1_x, req1_y, req1_ctl, input req1_ready,
      input  rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng, output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_x, req0_y, req0_ctl, output req0_ready,
      input  req1_valid, req1_x, req1_y, req1_ctl, output req1_ready,
      output rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng, input rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a two-stage Hack-style ALU, one operation in flight.
// ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties (no last-grant state).
module alu_arbiter #(
   parameter int W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state_r;
   state_t       state_s;
   logic         any_valid_s;
   logic         winner_s;
   logic         accept_s;
   logic         req0_ready_s;
   logic         req1_ready_s;
   logic [W-1:0] sel_x_s;
   logic [W-1:0] sel_y_s;
   logic [5:0]   sel_ctl_s;
   logic [W-1:0] x2_r;
   logic [W-1:0] y2_r;
   logic         f_r;
   logic         no_r;
   logic         id_r;
   logic [W-1:0] fo_s;
   logic [W-1:0] res_s;
   logic         rsp_valid_r;
   logic         rsp_id_r;
   logic [W-1:0] rsp_out_r;
   logic         rsp_zr_r;
   logic         rsp_ng_r;

   // Operand pre-conditioning: optional zeroing followed by optional inversion.
   function automatic logic [W-1:0] pre_op(input logic [W-1:0] v, input logic z, input logic n);
      logic [W-1:0] v1;
      v1 = z ? {W{1'b0}} : v;
      return n ? ~v1 : v1;
   endfunction

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic last_grant_r;

   // Last-grant memory for round-robin tie breaking; reset value lets requester 0 win first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= 1'b1;
      end else if (accept_s) begin
         last_grant_r <= winner_s;
      end
   end
`endif

   // Arbitration winner among the currently pending requests.
   always_comb begin
      any_valid_s = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         winner_s = 1'b0;
`else
         winner_s = ~last_grant_r;
`endif
      end else if (bus.req1_valid) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
   end

   // Winner operand select.
   always_comb begin
      if (winner_s) begin
         sel_x_s   = bus.req1_x;
         sel_y_s   = bus.req1_y;
         sel_ctl_s = bus.req1_ctl;
      end else begin
         sel_x_s   = bus.req0_x;
         sel_y_s   = bus.req0_y;
         sel_ctl_s = bus.req0_ctl;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = any_valid_s ? EXEC : IDLE;
         EXEC:    state_s = RESP;
         RESP:    state_s = bus.rsp_ready ? IDLE : RESP;
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs: grants are combinational so a request is taken in the cycle it is offered.
   always_comb begin
      accept_s     = 1'b0;
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
      case (state_r)
         IDLE: begin
            accept_s     = rst_n & any_valid_s;
            req0_ready_s = rst_n & any_valid_s & ~winner_s;
            req1_ready_s = rst_n & any_valid_s & winner_s;
         end
         EXEC:    accept_s = 1'b0;
         RESP:    accept_s = 1'b0;
         default: accept_s = 1'b0;
      endcase
   end

   // Stage 1: capture the winner's conditioned operands, function bits and id.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x2_r <= {W{1'b0}};
         y2_r <= {W{1'b0}};
         f_r  <= 1'b0;
         no_r <= 1'b0;
         id_r <= 1'b0;
      end else if (accept_s) begin
         x2_r <= pre_op(sel_x_s, sel_ctl_s[5], sel_ctl_s[4]);
         y2_r <= pre_op(sel_y_s, sel_ctl_s[3], sel_ctl_s[2]);
         f_r  <= sel_ctl_s[1];
         no_r <= sel_ctl_s[0];
         id_r <= winner_s;
      end
   end

   // Stage 2 function: add (carry dropped) or AND, then optional inversion.
   always_comb begin
      if (f_r) begin
         fo_s = x2_r + y2_r;
      end else begin
         fo_s = x2_r & y2_r;
      end
      if (no_r) begin
         res_s = ~fo_s;
      end else begin
         res_s = fo_s;
      end
   end

   // Response registers: loaded only in EXEC so they hold steady through RESP back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= 1'b0;
         rsp_out_r   <= {W{1'b0}};
         rsp_zr_r    <= 1'b0;
         rsp_ng_r    <= 1'b0;
      end else begin
         rsp_valid_r <= (state_s == RESP);
         if (state_r == EXEC) begin
            rsp_id_r  <= id_r;
            rsp_out_r <= res_s;
            rsp_zr_r  <= (res_s == {W{1'b0}});
            rsp_ng_r  <= res_s[W-1];
         end
      end
   end

   assign bus.req0_ready = req0_ready_s;
   assign bus.req1_ready = req1_ready_s;
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_id     = rsp_id_r;
   assign bus.rsp_out    = rsp_out_r;
   assign bus.rsp_zr     = rsp_zr_r;
   assign bus.rsp_ng     = rsp_ng_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; outputs sampled on the falling clock edge.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   alu_arbiter_if #(.W(16)) bus ();

   alu_arbiter #(.W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic id, input logic v, input logic [15:0] x,
                            input logic [15:0] y, input logic [5:0] ctl);
      if (id) begin
         bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_ctl = ctl;
      end else begin
         bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_ctl = ctl;
      end
   endtask

   // One operation from a single requester with rsp_ready held high.
   task automatic run_op(input logic id, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] ctl, input logic [15:0] eo,
                         input logic ezr, input logic eng);
      @(negedge clk);
      drive_req(id, 1'b1, x, y, ctl);
      #1;
      check_val("grant", 32'({bus.req1_ready, bus.req0_ready}), id ? 32'd2 : 32'd1);
      @(negedge clk);
      drive_req(id, 1'b0, x, y, ctl);
      check_val("exec_no_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("exec_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      @(negedge clk);
      check_val("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_val("rsp_out", 32'(bus.rsp_out), 32'(eo));
      check_val("rsp_id", 32'(bus.rsp_id), 32'(id));
      check_val("rsp_zr", 32'(bus.rsp_zr), 32'(ezr));
      check_val("rsp_ng", 32'(bus.rsp_ng), 32'(eng));
      @(negedge clk);
      check_val("rsp_drop", 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic gq[$];
      int   nacc;
      int   nrsp;
      int   last;
      logic exp_g;
      logic [15:0] held;

      drive_req(1'b0, 1'b1, 16'd0, 16'd0, 6'd0);
      drive_req(1'b1, 1'b1, 16'd0, 16'd0, 6'd0);
      bus.rsp_ready = 1'b1;
      #22;
      check_val("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      check_val("rst_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("rst_out", 32'(bus.rsp_out), 32'd0);
      check_val("rst_id_zr_ng", 32'({bus.rsp_id, bus.rsp_zr, bus.rsp_ng}), 32'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, 16'd5, 16'd3, 6'b000010, 16'd8, 1'b0, 1'b0);
      run_op(1'b0, 16'hFFFF, 16'd1, 6'b000010, 16'h0000, 1'b1, 1'b0);
      run_op(1'b1, 16'd3, 16'd5, 6'b010011, 16'hFFFE, 1'b0, 1'b1);
      run_op(1'b1, 16'hF0F0, 16'h3C3C, 6'b000000, 16'h3030, 1'b0, 1'b0);
      run_op(1'b0, 16'hF0F0, 16'h3C3C, 6'b000001, 16'hCFCF, 1'b0, 1'b1);

      // Fresh reset so the first tie goes to requester 0.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive_req(1'b0, 1'b1, 16'h1234, 16'h5678, 6'b101010);
      drive_req(1'b1, 1'b1, 16'h9ABC, 16'hDEF0, 6'b101010);
      nacc = 0;
      nrsp = 0;
      last = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         if (bus.req0_ready || bus.req1_ready) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = (nacc % 2 == 1);
`endif
            check_val("rr_grant", 32'({bus.req1_ready, bus.req0_ready}), exp_g ? 32'd2 : 32'd1);
            if (nacc > 0) check_val("rr_gap", 32'(cyc - last), 32'd3);
            gq.push_back(bus.req1_ready);
            last = cyc;
            nacc++;
         end
         if (bus.rsp_valid) begin
            check_val("rr_out", 32'(bus.rsp_out), 32'd0);
            check_val("rr_zr", 32'(bus.rsp_zr), 32'd1);
            if (gq.size() == 0) begin
               check_val("rr_orphan", 32'(bus.rsp_valid), 32'd0);
            end else begin
               check_val("rr_id", 32'(bus.rsp_id), 32'(gq.pop_front()));
            end
            nrsp++;
         end
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check_val("rr_nacc", 32'(nacc), 32'd4);
      check_val("rr_nrsp", 32'(nrsp), 32'd4);

      // Back-pressure in RESP with requester 1 waiting throughout.
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      drive_req(1'b0, 1'b1, 16'h1234, 16'h0001, 6'b000010);
      drive_req(1'b1, 1'b1, 16'd7, 16'd9, 6'b000010);
      #1;
      check_val("bp_grant0", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      check_val("bp_exec_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      @(negedge clk);
      check_val("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check_val("bp_out", 32'(bus.rsp_out), 32'h1235);
      held = bus.rsp_out;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_val("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
         check_val("bp_hold_out", 32'(bus.rsp_out), 32'(held));
         check_val("bp_hold_flags", 32'({bus.rsp_id, bus.rsp_zr, bus.rsp_ng}), 32'd0);
         check_val("bp_hold_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check_val("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("bp_release_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      @(negedge clk);
      check_val("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
      check_val("bp_next_out", 32'(bus.rsp_out), 32'd16);
      check_val("bp_next_id", 32'(bus.rsp_id), 32'd1);

      // Reset during EXEC discards the operation.
      @(negedge clk);
      drive_req(1'b1, 1'b1, 16'd1, 16'd1, 6'b000010);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      rst_n = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      check_val("er_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      check_val("er_valid", 32'(bus.rsp_valid), 32'd0);
      check_val("er_out", 32'(bus.rsp_out), 32'd0);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_val("er_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      drive_req(1'b0, 1'b1, 16'd9, 16'd9, 6'b101010);
      drive_req(1'b1, 1'b1, 16'd9, 16'd9, 6'b101010);
      #1;
      check_val("er_tie_grant0", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      check_val("er_rsp_id", 32'({bus.rsp_valid, bus.rsp_id}), 32'd2);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
